bram_port_controller: RTL and testbench



---
 rtl/bram_port_controller.sv | 216 +++++++++++++++++++++
 tb/tb_bram_port_controller.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_controller.sv
// bram_port_controller: initiator for one port of a true-dual-port no-change BRAM.
// Issues valid/ready read/write requests on the BRAM pins, tracks read latency,
// returns read data in order through a credit-protected response FIFO, and
// offers a clear/fill sequence writing init_value to every address.
// Optional build macro BRAM_CTRL_PARITY_EN: adds an even-parity bit as the MSB
// of the BRAM data word and a rsp_err output flagging parity mismatches.
module bram_port_controller #(
  parameter int unsigned DATA_WIDTH   = 18,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned RSP_DEPTH    = 4,
`ifdef BRAM_CTRL_PARITY_EN
  localparam int unsigned BW = DATA_WIDTH + 1
`else
  localparam int unsigned BW = DATA_WIDTH
`endif
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
`ifdef BRAM_CTRL_PARITY_EN
  output logic                  rsp_err,
`endif
  input  logic                  init_start,
  input  logic [DATA_WIDTH-1:0] init_value,
  output logic                  init_busy,
  output logic                  init_done,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [BW-1:0]         bram_din,
  output logic                  bram_regce,
  output logic                  bram_rst,
  input  logic [BW-1:0]         bram_dout
);

  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
`ifdef BRAM_CTRL_PARITY_EN
  localparam int unsigned FW = DATA_WIDTH + 1;
`else
  localparam int unsigned FW = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_INIT  = 2'd2
  } state_e;

  // Build the BRAM write word (parity bit on top when enabled).
  function automatic logic [BW-1:0] encode(input logic [DATA_WIDTH-1:0] data);
`ifdef BRAM_CTRL_PARITY_EN
    return {^data, data};
`else
    return data;
`endif
  endfunction

  state_e                  state_q, state_d;
  logic [CW-1:0]           outstanding_q, outstanding_d;
  logic                    en_q, en_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BW-1:0]           din_q, din_d;
  logic                    brst_q, brst_d;
  logic                    init_busy_q, init_busy_d;
  logic                    init_done_q, init_done_d;
  logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic [FW-1:0]           fifo_q [RSP_DEPTH];
  logic [FW-1:0]           fifo_d [RSP_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  logic          accept;
  logic          accept_rd;
  logic          issue_rd;
  logic          push;
  logic          pop;
  logic [FW-1:0] push_entry;

  // Handshake qualifiers; ready only looks at state and credit.
  assign req_ready = rsta_n && (state_q == ST_IDLE) && (outstanding_q < CW'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign accept_rd = accept && !req_we;
  assign issue_rd  = en_q && !we_q;
  assign push      = rd_pipe_q[READ_LATENCY-1];
  assign pop       = rsp_valid && rsp_ready;

`ifdef BRAM_CTRL_PARITY_EN
  // XOR across data and stored parity is 1 exactly on a mismatch.
  assign push_entry = {(^bram_dout), bram_dout[DATA_WIDTH-1:0]};
`else
  assign push_entry = bram_dout;
`endif

  // Next-state and BRAM pin drive: host requests in IDLE, fill writes in INIT.
  always_comb begin
    state_d     = state_q;
    en_d        = 1'b0;
    we_d        = 1'b0;
    addr_d      = '0;
    din_d       = '0;
    brst_d      = 1'b0;
    init_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          en_d   = 1'b1;
          we_d   = req_we;
          addr_d = req_addr;
          din_d  = encode(req_wdata);
        end
        if (init_start) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!issue_rd && (rd_pipe_q == '0)) begin
          state_d = ST_INIT;
          en_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = '0;
          din_d   = encode(init_value);
        end
      end
      ST_INIT: begin
        if (addr_q == LAST_ADDR) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          en_d   = 1'b1;
          we_d   = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(1);
          din_d  = encode(init_value);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    init_busy_d = (state_d != ST_IDLE);
  end

  // Read-latency tags, response FIFO bookkeeping and outstanding-read credit.
  always_comb begin
    rd_pipe_d    = '0;
    rd_pipe_d[0] = issue_rd;
    for (int i = 1; i < int'(READ_LATENCY); i++) rd_pipe_d[i] = rd_pipe_q[i-1];
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_entry;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d       = count_q + CW'(push) - CW'(pop);
    outstanding_d = outstanding_q + CW'(accept_rd) - CW'(pop);
  end

  // State and datapath registers; reset clears all control asynchronously.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q       <= ST_IDLE;
      outstanding_q <= '0;
      en_q          <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      din_q         <= '0;
      brst_q        <= 1'b1;
      init_busy_q   <= 1'b0;
      init_done_q   <= 1'b0;
      rd_pipe_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < int'(RSP_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      en_q          <= en_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      brst_q        <= brst_d;
      init_busy_q   <= init_busy_d;
      init_done_q   <= init_done_d;
      rd_pipe_q     <= rd_pipe_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      fifo_q        <= fifo_d;
    end
  end

  assign bram_en    = en_q;
  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_din   = din_q;
  assign bram_regce = 1'b1;
  assign bram_rst   = brst_q;
  assign init_busy  = init_busy_q;
  assign init_done  = init_done_q;
  assign rsp_valid  = (count_q != '0);
  assign rsp_rdata  = fifo_q[rd_ptr_q][DATA_WIDTH-1:0];
`ifdef BRAM_CTRL_PARITY_EN
  assign rsp_err    = fifo_q[rd_ptr_q][DATA_WIDTH];
`endif

endmodule

// File: tb/tb_bram_port_controller.sv
// Testbench for bram_port_controller: behavioural BRAM, reference memory and
// expected-response queue, directed scenarios plus randomized traffic.
module tb_bram_port_controller;

  localparam int unsigned DW    = 18;
  localparam int unsigned AW    = 4;
  localparam int unsigned RL    = 2;
  localparam int unsigned RD    = 4;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef BRAM_CTRL_PARITY_EN
  localparam int unsigned BW = DW + 1;
`else
  localparam int unsigned BW = DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err_v;
  logic          init_start, init_busy, init_done;
  logic [DW-1:0] init_value;
  logic          bram_en, bram_we, bram_regce, bram_rst;
  logic [AW-1:0] bram_addr;
  logic [BW-1:0] bram_din, bram_dout;
`ifdef BRAM_CTRL_PARITY_EN
  logic          rsp_err;
  assign rsp_err_v = rsp_err;
`else
  assign rsp_err_v = 1'b0;
`endif

  always #5 clk = ~clk;

  bram_port_controller #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .RSP_DEPTH(RD)
  ) u_dut (
    .clka(clk), .rsta_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
`ifdef BRAM_CTRL_PARITY_EN
    .rsp_err(rsp_err),
`endif
    .init_start(init_start), .init_value(init_value),
    .init_busy(init_busy), .init_done(init_done),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_regce(bram_regce), .bram_rst(bram_rst),
    .bram_dout(bram_dout)
  );

  // Behavioural no-change BRAM port with optional output register.
  logic [BW-1:0] bmem [DEPTH];
  logic [BW-1:0] lat1 = '0;
  logic [BW-1:0] lat2 = '0;
  logic          flip = 1'b0;
  logic [BW-1:0] flip_mask;
  assign flip_mask = {flip, {(BW-1){1'b0}}};

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) bmem[bram_addr] <= bram_din;
      else         lat1 <= bmem[bram_addr];
    end
    if (bram_rst)        lat2 <= '0;
    else if (bram_regce) lat2 <= lat1;
  end
  assign bram_dout = ((RL == 1) ? lat1 : lat2) ^ flip_mask;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memory image and queue of expected {err, data} responses.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW:0]   expq [$];
  int n_cmp = 0;
  int n_mis = 0;
  int init_cnt = 0;
  int init_first = 0;
  int init_last = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: credit/busy rules, fill sequence, response order and stability.
  initial begin
    logic        hold_v;
    logic [DW:0] hold_d;
    logic [DW:0] e;
    hold_v = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        expq.delete();
        hold_v = 1'b0;
      end else begin
        if (req_ready) check("ready_credit", 32'(expq.size() < RD), 32'd1);
        if (init_busy) check("ready_busy", 32'(req_ready), 32'd0);
        if (init_busy && bram_en && bram_we) begin
          check("init_addr", 32'(bram_addr), 32'(init_cnt));
          check("init_din", 32'(bram_din[DW-1:0]), 32'(init_value));
          if (init_cnt == 0) init_first = cyc;
          init_last = cyc;
          init_cnt++;
        end
        if (init_done) foreach (ref_mem[i]) ref_mem[i] = init_value;
        if (hold_v) begin
          check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
          check("rsp_hold_data", 32'({rsp_err_v, rsp_rdata}), 32'(hold_d));
        end
        if (req_valid && req_ready) begin
          if (req_we) ref_mem[req_addr] = req_wdata;
          else        expq.push_back({flip, ref_mem[req_addr]});
        end
        if (rsp_valid && rsp_ready) begin
          check("rsp_expected", 32'(expq.size() != 0), 32'd1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            check("rsp_data", 32'(rsp_rdata), 32'(e[DW-1:0]));
`ifdef BRAM_CTRL_PARITY_EN
            check("rsp_err", 32'(rsp_err), 32'(e[DW]));
`endif
          end
        end
        hold_v = rsp_valid && !rsp_ready;
        hold_d = {rsp_err_v, rsp_rdata};
      end
    end
  end

  // All drive tasks start and end #1 after a rising edge.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("send_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while ((expq.size() != 0 || rsp_valid) && t < 200) begin @(posedge clk); #1; t++; end
    check("drain_empty", 32'(expq.size()) + 32'(rsp_valid), 32'd0);
  endtask

  task automatic fill_random();
    for (int a = 0; a < int'(DEPTH); a++) send(1'b1, AW'(a), DW'($urandom));
  endtask

  task automatic readback_all();
    for (int a = 0; a < int'(DEPTH); a++) send(1'b0, AW'(a), '0);
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t, lat, nacc;
    logic acc;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; init_start = 1'b0; init_value = '0;
    rst_n = 1'b0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_bram_en", 32'(bram_en), 32'd0);
    check("rst_bram_rst", 32'(bram_rst), 32'd1);
    check("rst_init_busy", 32'(init_busy), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rel_bram_rst", 32'(bram_rst), 32'd1);
    check("rel_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("bram_rst_off", 32'(bram_rst), 32'd0);
    check("bram_regce", 32'(bram_regce), 32'd1);

    fill_random();

    // Single write then read of the same address: pins, latency, data.
    send(1'b1, AW'(3), DW'(18'h155));
    @(negedge clk);
    check("wr_pin_en", 32'(bram_en), 32'd1);
    check("wr_pin_we", 32'(bram_we), 32'd1);
    check("wr_pin_addr", 32'(bram_addr), 32'd3);
    check("wr_pin_din", 32'(bram_din[DW-1:0]), 32'h155);
    @(negedge clk);
    check("wr_pin_one_cycle", 32'(bram_en), 32'd0);
    @(posedge clk); #1;
    send(1'b0, AW'(3), '0);
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin lat++; @(negedge clk); end
    check("rd_latency", 32'(lat), 32'(2 + RL));
    check("rd_data_155", 32'(rsp_rdata), 32'h155);
    @(posedge clk); #1;
    wait_drain();

    // Backpressure: only RSP_DEPTH reads accepted while responses are held.
    for (int a = 0; a < 6; a++) send(1'b1, AW'(a), DW'(32'h1000 + a));
    rsp_ready = 1'b0;
    nacc = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc) begin nacc++; req_addr = AW'(nacc); if (nacc == 6) req_valid = 1'b0; end
    end
    check("bp_accepted", 32'(nacc), 32'd4);
    check("bp_ready_low", 32'(req_ready), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    t = 0;
    while (nacc < 6 && t < 50) begin
      @(negedge clk); acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc) begin nacc++; req_addr = AW'(nacc); if (nacc == 6) req_valid = 1'b0; end
      t++;
    end
    check("bp_rest_accepted", 32'(nacc), 32'd6);
    wait_drain();

    // Randomized traffic with random response backpressure.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); acc = req_valid && req_ready;
      @(posedge clk); #1;
      rsp_ready = 1'($urandom_range(0, 3) != 0);
      if (acc || !req_valid) begin
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
      end
    end
    wait_drain();

    // Fill with two reads in flight, then read everything back.
    init_value = DW'(18'h2A5);
    init_cnt = 0;
    send(1'b0, AW'(1), '0);
    send(1'b0, AW'(2), '0);
    init_start = 1'b1; @(posedge clk); #1; init_start = 1'b0;
    t = 0;
    @(negedge clk);
    while (!init_done && t < 100) begin t++; @(negedge clk); end
    check("init_done_seen", 32'(init_done), 32'd1);
    check("init_busy_drop", 32'(init_busy), 32'd0);
    check("init_writes", 32'(init_cnt), 32'(DEPTH));
    check("init_consecutive", 32'(init_last - init_first), 32'(DEPTH - 1));
    @(negedge clk);
    check("init_done_pulse", 32'(init_done), 32'd0);
    @(posedge clk); #1;
    readback_all();

`ifdef BRAM_CTRL_PARITY_EN
    // Parity bit written, then a corrupted and a clean readback.
    send(1'b1, AW'(5), DW'(18'h001));
    @(negedge clk);
    check("par_din_msb", 32'(bram_din[BW-1]), 32'd1);
    @(posedge clk); #1;
    flip = 1'b1;
    send(1'b0, AW'(5), '0);
    wait_drain();
    flip = 1'b0;
    send(1'b0, AW'(5), '0);
    wait_drain();
`endif

    // Reset asserted while the fill is on address 7.
    fill_random();
    init_value = DW'(18'h1E1E1);
    init_cnt = 0;
    init_start = 1'b1; @(posedge clk); #1; init_start = 1'b0;
    t = 0;
    @(negedge clk);
    while (!(init_busy && bram_we && bram_addr == AW'(7)) && t < 100) begin t++; @(negedge clk); end
    check("mid_init_addr7", 32'(bram_addr), 32'd7);
    rst_n = 1'b0; #1;
    check("mid_rst_bram_en", 32'(bram_en), 32'd0);
    check("mid_rst_busy", 32'(init_busy), 32'd0);
    check("mid_rst_bram_rst", 32'(bram_rst), 32'd1);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    for (int a = 0; a < 7; a++) ref_mem[a] = init_value;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    readback_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
